// File: rtl/axi4s_divider_pkg.sv
// Shared encodings and saturation constants for the stream divider datapath.
package axi4s_divider_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SETUP   = 2'd1,
      DIV     = 2'd2,
      DONE    = 2'd3
   } div_state_e;

   // Largest positive Q1.(w-1) value, returned in a 64-bit container (w <= 64).
   function automatic logic [63:0] q_max(input int unsigned w);
      q_max = (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative Q1.(w-1) value (-1.0), returned in a 64-bit container.
   function automatic logic [63:0] q_min(input int unsigned w);
      q_min = 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/axi4s_divider_shift_and_subtract.sv
// Restoring shift-and-subtract magnitude divider. The first iteration runs
// on the load edge, so WIDTH-1 quotient bits take WIDTH-1 edges in total.
// Requires dividend_mag < divisor_mag.
module shift_and_subtract_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] dividend_mag,
   input  logic [WIDTH-1:0] divisor_mag,
   input  logic             input_valid,
   output logic [WIDTH-1:0] quotient_mag,
   output logic             ready
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   div_q;
   logic [WIDTH-1:0] quot;
   logic [CW-1:0]    count;
   logic             busy;

   logic [WIDTH:0]   rem_src;
   logic [WIDTH:0]   div_src;
   logic [WIDTH:0]   rem_shl;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;

   // One restoring step, fed from the ports on load or from the registers otherwise.
   always_comb begin
      rem_src  = input_valid ? {1'b0, dividend_mag} : rem;
      div_src  = input_valid ? {1'b0, divisor_mag} : div_q;
      rem_shl  = rem_src << 1;
      q_bit    = (rem_shl >= div_src);
      rem_next = q_bit ? (rem_shl - div_src) : rem_shl;
   end

   // Iteration registers with a down-counter of remaining steps; ready pulses once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem   <= '0;
         div_q <= '0;
         quot  <= '0;
         count <= '0;
         busy  <= 1'b0;
         ready <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (input_valid) begin
            rem   <= rem_next;
            div_q <= div_src;
            quot  <= {{(WIDTH-1){1'b0}}, q_bit};
            count <= CNT_LOAD;
            busy  <= 1'b1;
         end else if (busy) begin
            rem   <= rem_next;
            quot  <= {quot[WIDTH-2:0], q_bit};
            count <= count - 1'b1;
            if (count == CNT_LAST) begin
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         end
      end
   end

   assign quotient_mag = quot;

endmodule

// File: rtl/axi4s_divider.sv
// AXI4-Stream Q1.(W-1) fixed-point divider with saturation flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// COLLECT | gather dividend/divisor, wait for a free output register
// SETUP   | take signs/magnitudes, decide saturation or start divider
// DIV     | magnitude loop running in the sub-module
// DONE    | load result into the master register, reopen the slaves
module axi4s_divider
   import axi4s_divider_pkg::*;
#(
   parameter int DATA_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tvalid_slave_1,
   input  logic [8*DATA_BYTES-1:0] tdata_slave_1,
   output logic                    tready_slave_1,
   input  logic                    tvalid_slave_2,
   input  logic [8*DATA_BYTES-1:0] tdata_slave_2,
   output logic                    tready_slave_2,
   output logic                    tvalid_master,
   output logic [8*DATA_BYTES-1:0] tdata_master,
   output logic                    tuser_master,
   input  logic                    tready_master
);

   localparam int W = 8 * DATA_BYTES;
   localparam logic [63:0] Q_MAX_L = q_max(W);
   localparam logic [63:0] Q_MIN_L = q_min(W);
   localparam logic [W-1:0] Q_MAX = Q_MAX_L[W-1:0];
   localparam logic [W-1:0] Q_MIN = Q_MIN_L[W-1:0];

   div_state_e     state, state_next;
   logic [W-1:0]   a_q, b_q;
   logic           have_a, have_b;
   logic           have_a_nxt, have_b_nxt;
   logic           sign_q, sat_q;
   logic           hs_a, hs_b;
   logic           start;
   logic [W-1:0]   mag_a, mag_b;
   logic           sat_now;
   logic [W-1:0]   quot_mag;
   logic           div_ready;
   logic [W-1:0]   result;

   assign hs_a = tvalid_slave_1 & tready_slave_1;
   assign hs_b = tvalid_slave_2 & tready_slave_2;
   assign have_a_nxt = (state == DONE) ? 1'b0 : (have_a | hs_a);
   assign have_b_nxt = (state == DONE) ? 1'b0 : (have_b | hs_b);

   // Magnitudes and saturation test on the latched operands; |-1.0| fits as unsigned.
   always_comb begin
      mag_a   = a_q[W-1] ? (~a_q + 1'b1) : a_q;
      mag_b   = b_q[W-1] ? (~b_q + 1'b1) : b_q;
      sat_now = (mag_b == '0) || (mag_a >= mag_b);
      if (sat_q) result = sign_q ? Q_MIN : Q_MAX;
      else       result = sign_q ? (~quot_mag + 1'b1) : quot_mag;
   end

   // Next-state logic; an operand arriving this cycle counts as already held.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         COLLECT: if ((have_a | hs_a) && (have_b | hs_b) &&
                      (!tvalid_master || tready_master))
                     state_next = SETUP;
         SETUP: begin
            if (sat_now) begin
               state_next = DONE;
            end else begin
               start      = 1'b1;
               state_next = DIV;
            end
         end
         DIV:     if (div_ready) state_next = DONE;
         DONE:    state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= COLLECT;
      else          state <= state_next;
   end

   // Operand capture; each slave is ready exactly while its operand slot is empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q            <= '0;
         b_q            <= '0;
         have_a         <= 1'b0;
         have_b         <= 1'b0;
         tready_slave_1 <= 1'b0;
         tready_slave_2 <= 1'b0;
      end else begin
         if (hs_a) a_q <= tdata_slave_1;
         if (hs_b) b_q <= tdata_slave_2;
         have_a         <= have_a_nxt;
         have_b         <= have_b_nxt;
         tready_slave_1 <= !have_a_nxt;
         tready_slave_2 <= !have_b_nxt;
      end
   end

   // Sign and saturation decision; divide-by-zero follows the dividend sign.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_q <= 1'b0;
         sat_q  <= 1'b0;
      end else if (state == SETUP) begin
         sign_q <= (mag_b == '0) ? a_q[W-1] : (a_q[W-1] ^ b_q[W-1]);
         sat_q  <= sat_now;
      end
   end

   // Master output register: loaded in DONE, held until the downstream handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tvalid_master <= 1'b0;
         tdata_master  <= '0;
         tuser_master  <= 1'b0;
      end else if (state == DONE) begin
         tvalid_master <= 1'b1;
         tdata_master  <= result;
         tuser_master  <= sat_q;
      end else if (tready_master) begin
         tvalid_master <= 1'b0;
      end
   end

   shift_and_subtract_divider #(.WIDTH(W)) u_sas (
      .clk          (clk),
      .reset_n      (reset_n),
      .dividend_mag (mag_a),
      .divisor_mag  (mag_b),
      .input_valid  (start),
      .quotient_mag (quot_mag),
      .ready        (div_ready)
   );

endmodule

// File: tb/tb_axi4s_divider.sv
// Bench for axi4s_divider: directed vectors, random pairs against an
// arithmetic reference, backpressure and mid-division reset.
module tb_axi4s_divider;

   localparam int W = 16;
   localparam int LAT_DIV = W + 1;
   localparam int LAT_SAT = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         tvalid_slave_1 = 1'b0;
   logic [W-1:0] tdata_slave_1 = '0;
   logic         tready_slave_1;
   logic         tvalid_slave_2 = 1'b0;
   logic [W-1:0] tdata_slave_2 = '0;
   logic         tready_slave_2;
   logic         tvalid_master;
   logic [W-1:0] tdata_master;
   logic         tuser_master;
   logic         tready_master = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi4s_divider #(.DATA_BYTES(W/8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tvalid_slave_1 (tvalid_slave_1),
      .tdata_slave_1  (tdata_slave_1),
      .tready_slave_1 (tready_slave_1),
      .tvalid_slave_2 (tvalid_slave_2),
      .tdata_slave_2  (tdata_slave_2),
      .tready_slave_2 (tready_slave_2),
      .tvalid_master  (tvalid_master),
      .tdata_master   (tdata_master),
      .tuser_master   (tuser_master),
      .tready_master  (tready_master)
   );

   // Reference: exact signed arithmetic with saturation, truncation toward zero.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic sat);
      longint sa, sb, ma, mb, mag, qv;
      bit neg;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      if (mb == 0) begin
         neg = (sa < 0);
         sat = 1'b1;
      end else begin
         neg = (sa < 0) != (sb < 0);
         sat = (ma >= mb);
      end
      if (sat) begin
         qv = neg ? -(longint'(1) << (W-1)) : ((longint'(1) << (W-1)) - 1);
      end else begin
         mag = (ma * (longint'(1) << (W-1))) / mb;
         qv  = neg ? -mag : mag;
      end
      q = qv[W-1:0];
   endfunction

   // Present both operands (b delayed by gap cycles); returns at the negedge of
   // the cycle following the later handshake.
   task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
      bit d1, d2, h1, h2;
      int t;
      d1 = 0; d2 = 0; t = 0;
      tdata_slave_1  = a;
      tdata_slave_2  = b;
      tvalid_slave_1 = 1'b1;
      while (!(d1 && d2) && t < 100) begin
         if (t >= gap && !d2) tvalid_slave_2 = 1'b1;
         h1 = tvalid_slave_1 && tready_slave_1;
         h2 = tvalid_slave_2 && tready_slave_2;
         @(negedge clk);
         t++;
         if (h1) begin d1 = 1; tvalid_slave_1 = 1'b0; end
         if (h2) begin d2 = 1; tvalid_slave_2 = 1'b0; end
      end
      tvalid_slave_1 = 1'b0;
      tvalid_slave_2 = 1'b0;
      checks++;
      if (!(d1 && d2)) begin
         errors++;
         $display("FAIL send_pair_timeout a=%h b=%h got_a=%0d got_b=%0d want both 1", a, b, d1, d2);
      end
   endtask

   // Wait for tvalid_master, counting cycles from the current one.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!tvalid_master && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                        output logic [W-1:0] q, output logic u, output int lat);
      send_pair(a, b, gap);
      wait_result(lat);
      q = tdata_master;
      u = tuser_master;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tready_slave_1, tready_slave_2, tvalid_master, tuser_master, tdata_master} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got r1=%b r2=%b v=%b u=%b d=%h want all 0",
                  tready_slave_1, tready_slave_2, tvalid_master, tuser_master, tdata_master);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (tready_slave_1 !== 1'b0 || tready_slave_2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready got r1=%b r2=%b want 0 0", tready_slave_1, tready_slave_2);
      end
      @(negedge clk);
      checks++;
      if (tready_slave_1 !== 1'b1 || tready_slave_2 !== 1'b1) begin
         errors++;
         $display("FAIL first_edge_ready got r1=%b r2=%b want 1 1", tready_slave_1, tready_slave_2);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [10] = '{16'h2000, 16'hE000, 16'h2000, 16'hE000, 16'h4000,
                               16'hC000, 16'h8000, 16'h1000, 16'h0001, 16'hFFFF};
      logic [W-1:0] vb [10] = '{16'h4000, 16'h4000, 16'hC000, 16'hC000, 16'h2000,
                               16'h2000, 16'h8000, 16'h0000, 16'h0003, 16'h0003};
      logic [W-1:0] vq [10] = '{16'h4000, 16'hC000, 16'hC000, 16'h4000, 16'h7FFF,
                               16'h8000, 16'h7FFF, 16'h7FFF, 16'h2AAA, 16'hD556};
      logic         vu [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      logic [W-1:0] q;
      logic u;
      int lat, exp_lat;
      for (int i = 0; i < 10; i++) begin
         do_op(va[i], vb[i], i % 3, q, u, lat);
         exp_lat = vu[i] ? LAT_SAT : LAT_DIV;
         checks++;
         if (q !== vq[i]) begin
            errors++;
            $display("FAIL directed_data a=%h b=%h got %h want %h", va[i], vb[i], q, vq[i]);
         end
         checks++;
         if (u !== vu[i]) begin
            errors++;
            $display("FAIL directed_tuser a=%h b=%h got %b want %b", va[i], vb[i], u, vu[i]);
         end
         checks++;
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL directed_latency a=%h b=%h got %0d want %0d", va[i], vb[i], lat, exp_lat);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, q, eq;
      logic u, eu;
      int lat;
      for (int i = 0; i < 40; i++) begin
         b = W'($urandom);
         a = W'($urandom);
         if ($urandom_range(0, 2) != 0) a = W'($signed(a) >>> $urandom_range(1, 8));
         model(a, b, eq, eu);
         do_op(a, b, $urandom_range(0, 3), q, u, lat);
         checks++;
         if (q !== eq || u !== eu) begin
            errors++;
            $display("FAIL random_result a=%h b=%h got %h/%b want %h/%b", a, b, q, u, eq, eu);
         end
         checks++;
         if (lat != (eu ? LAT_SAT : LAT_DIV)) begin
            errors++;
            $display("FAIL random_latency a=%h b=%h got %0d want %0d", a, b, lat, eu ? LAT_SAT : LAT_DIV);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] q0, eq0, eq1;
      logic u0, eu0, eu1;
      bit d1, d2, h1, h2;
      int lat, rises;
      model(16'h1000, 16'h4000, eq0, eu0);
      model(16'h0800, 16'hC000, eq1, eu1);
      tready_master = 1'b0;
      send_pair(16'h1000, 16'h4000, 0);
      wait_result(lat);
      q0 = tdata_master;
      u0 = tuser_master;
      checks++;
      if (q0 !== eq0 || u0 !== eu0) begin
         errors++;
         $display("FAIL bp_first_result got %h/%b want %h/%b", q0, u0, eq0, eu0);
      end
      tdata_slave_1 = 16'h0800;
      tdata_slave_2 = 16'hC000;
      tvalid_slave_1 = 1'b1;
      tvalid_slave_2 = 1'b1;
      d1 = 0; d2 = 0;
      for (int c = 0; c < 5; c++) begin
         h1 = tvalid_slave_1 && tready_slave_1;
         h2 = tvalid_slave_2 && tready_slave_2;
         @(negedge clk);
         if (h1) begin d1 = 1; tvalid_slave_1 = 1'b0; end
         if (h2) begin d2 = 1; tvalid_slave_2 = 1'b0; end
         checks++;
         if (tvalid_master !== 1'b1 || tdata_master !== q0 || tuser_master !== u0) begin
            errors++;
            $display("FAIL bp_stable cycle=%0d got v=%b d=%h u=%b want 1 %h %b",
                     c, tvalid_master, tdata_master, tuser_master, q0, u0);
         end
      end
      tvalid_slave_1 = 1'b0;
      tvalid_slave_2 = 1'b0;
      checks++;
      if (!(d1 && d2)) begin
         errors++;
         $display("FAIL bp_accept_during_stall got a=%0d b=%0d want 1 1", d1, d2);
      end
      tready_master = 1'b1;
      @(negedge clk);
      checks++;
      if (tvalid_master !== 1'b0) begin
         errors++;
         $display("FAIL bp_valid_drop got %b want 0", tvalid_master);
      end
      wait_result(lat);
      checks++;
      if (lat != LAT_DIV || tdata_master !== eq1 || tuser_master !== eu1) begin
         errors++;
         $display("FAIL bp_second_result got lat=%0d %h/%b want lat=%0d %h/%b",
                  lat, tdata_master, tuser_master, LAT_DIV, eq1, eu1);
      end
      @(negedge clk);
      rises = 0;
      for (int c = 0; c < 25; c++) begin
         if (tvalid_master) rises++;
         @(negedge clk);
      end
      checks++;
      if (rises != 0) begin
         errors++;
         $display("FAIL bp_duplicate got %0d extra valid cycles want 0", rises);
      end
   endtask

   task automatic test_reset_mid_div();
      logic [W-1:0] q, eq;
      logic u, eu;
      int lat, seen;
      send_pair(16'h2000, 16'h4000, 1);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({tready_slave_1, tready_slave_2, tvalid_master, tuser_master, tdata_master} !== '0) begin
         errors++;
         $display("FAIL middiv_reset_async got r1=%b r2=%b v=%b u=%b d=%h want all 0",
                  tready_slave_1, tready_slave_2, tvalid_master, tuser_master, tdata_master);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (tvalid_master) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL middiv_no_output got %0d valid cycles want 0", seen);
      end
      model(16'hE000, 16'h7000, eq, eu);
      do_op(16'hE000, 16'h7000, 0, q, u, lat);
      checks++;
      if (q !== eq || u !== eu || lat != LAT_DIV) begin
         errors++;
         $display("FAIL middiv_recovery got %h/%b lat=%0d want %h/%b lat=%0d",
                  q, u, lat, eq, eu, LAT_DIV);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
